// File: rtl/axi_rd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : Round-robin arbiter sharing one AXI4 read master (AR + R) between
//            NUM_REQ internal requesters. One INCR burst outstanding at a
//            time; R beats are routed back to the requester that owns the
//            burst.
// Ports    : clk, rst_n (async, active-low)
//            req_valid/req_addr/req_len/req_ready : per-requester burst request
//            rd_data/rd_resp/rd_last (shared), rd_valid/rd_ready (per requester)
//            axi_ar* : AXI read address channel (master side)
//            axi_r*  : AXI read data channel (master side)
//            err_rid : sticky RID mismatch flag
// Options  : AXI_RD_ARB_RID_CHECK_EN - when defined, every accepted R beat has
//            its RID compared to the issued ARID; a mismatch sets err_rid until
//            reset. When undefined, err_rid is 0 and axi_rid is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0]          req_len,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic [1:0]                    rd_resp,
    output logic                          rd_last,
    output logic [NUM_REQ-1:0]            rd_valid,
    input  logic [NUM_REQ-1:0]            rd_ready,
    output logic [ID_WIDTH-1:0]           axi_arid,
    output logic [ADDR_WIDTH-1:0]         axi_araddr,
    output logic [7:0]                    axi_arlen,
    output logic [2:0]                    axi_arsize,
    output logic [1:0]                    axi_arburst,
    output logic                          axi_arvalid,
    input  logic                          axi_arready,
    input  logic [ID_WIDTH-1:0]           axi_rid,
    input  logic [DATA_WIDTH-1:0]         axi_rdata,
    input  logic [1:0]                    axi_rresp,
    input  logic                          axi_rlast,
    input  logic                          axi_rvalid,
    output logic                          axi_rready,
    output logic                          err_rid
);

    localparam int              IDX_W      = $clog2(NUM_REQ);
    localparam logic [1:0]      S_IDLE     = 2'd0;
    localparam logic [1:0]      S_ADDR     = 2'd1;
    localparam logic [1:0]      S_DATA     = 2'd2;
    localparam logic [2:0]      C_ARSIZE   = 3'($clog2(DATA_WIDTH/8));
    localparam logic [1:0]      C_ARBURST  = 2'b01;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ-1);

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      r_grant;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [7:0]            r_arlen;
    logic                  r_arvalid;
    logic                  r_err_rid;

    logic                  w_any;
    logic [IDX_W-1:0]      w_pick;
    logic [IDX_W-1:0]      w_idx;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [7:0]            w_sel_len;
    logic                  w_grant_now;
    logic                  w_in_data;
    logic                  w_beat;

    // Walk the requesters starting at r_rr_ptr, wrapping at NUM_REQ, and
    // take the first one with a pending request.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_any && req_valid[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
            w_idx = (w_idx == C_LAST_IDX) ? '0 : w_idx + IDX_W'(1);
        end
    end

    // Select the winning requester's address/length slice.
    always_comb begin
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == IDX_W'(i)) begin
                w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_len  = req_len[i*8 +: 8];
            end
        end
    end

    // rst_n gates the accept pulse so req_ready drops at once on reset even
    // while a requester keeps req_valid high.
    assign w_grant_now = rst_n && (r_state == S_IDLE) && w_any;
    assign w_in_data   = (r_state == S_DATA);
    assign w_beat      = w_in_data && axi_rvalid && axi_rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_araddr  <= '0;
            r_arlen   <= '0;
            r_arvalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant   <= w_pick;
                        r_araddr  <= w_sel_addr;
                        r_arlen   <= w_sel_len;
                        r_arvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rr_ptr  <= (r_grant == C_LAST_IDX) ? '0 : r_grant + IDX_W'(1);
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    // rlast alone closes the burst, whatever arlen said.
                    if (w_beat && axi_rlast) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef AXI_RD_ARB_RID_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_rid <= 1'b0;
        end else if (w_beat && (axi_rid != ID_WIDTH'(r_grant))) begin
            r_err_rid <= 1'b1;
        end
    end
`else
    logic w_unused_rid;
    assign w_unused_rid = ^axi_rid;
    assign r_err_rid    = 1'b0;
`endif

    assign req_ready   = w_grant_now ? (NUM_REQ'(1) << w_pick) : '0;

    assign axi_arid    = ID_WIDTH'(r_grant);
    assign axi_araddr  = r_araddr;
    assign axi_arlen   = r_arlen;
    assign axi_arsize  = C_ARSIZE;
    assign axi_arburst = C_ARBURST;
    assign axi_arvalid = r_arvalid;

    // R channel: only the owner of the burst sees valid or drives ready;
    // outside DATA the slave is stalled.
    assign rd_valid    = (w_in_data && axi_rvalid) ? (NUM_REQ'(1) << r_grant) : '0;
    assign axi_rready  = w_in_data && rd_ready[r_grant];
    assign rd_data     = axi_rdata;
    assign rd_resp     = axi_rresp;
    assign rd_last     = axi_rlast;

    assign err_rid     = r_err_rid;

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Purpose  : Self-checking bench for axi_rd_arbiter. A driver plays the
//            requesters and an AXI slave; a monitor keeps a transaction-level
//            model (round-robin owner, outstanding burst) and pops expected
//            read beats from per-requester queues filled at request time.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int IW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*8-1:0]  req_len = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   rd_data;
    logic [1:0]      rd_resp;
    logic            rd_last;
    logic [N-1:0]    rd_valid;
    logic [N-1:0]    rd_ready = '0;
    logic [IW-1:0]   axi_arid;
    logic [AW-1:0]   axi_araddr;
    logic [7:0]      axi_arlen;
    logic [2:0]      axi_arsize;
    logic [1:0]      axi_arburst;
    logic            axi_arvalid;
    logic            axi_arready = 1'b0;
    logic [IW-1:0]   axi_rid = '0;
    logic [DW-1:0]   axi_rdata = '0;
    logic [1:0]      axi_rresp = '0;
    logic            axi_rlast = 1'b0;
    logic            axi_rvalid = 1'b0;
    logic            axi_rready;
    logic            err_rid;

    axi_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
        .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .err_rid(err_rid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected read beats per requester: {last, data}
    logic [DW:0] exp_q [N][$];
    int          grant_log[$];

    function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int b);
        return (a + AW'(b * 4)) ^ 32'h5A3C_0F00;
    endfunction

    // ---------------- driver state ----------------
    bit            pend[N];
    logic [AW-1:0] d_addr[N];
    logic [7:0]    d_len[N];
    int            auto_reissue[N];
    int            rdy_hold[N];
    bit            rand_mode = 0;
    bit            bad_rid = 0;
    int            ar_hold = 0;
    int            hold_req = -1;
    int            ar_stalls = 0;
    int            r_stalls = 0;
    bit            s_busy = 0;
    logic [AW-1:0] s_addr;
    logic [7:0]    s_len;
    int            s_beat;
    logic [IW-1:0] s_id;

    task automatic issue(input int i, input logic [AW-1:0] a, input logic [7:0] l);
        pend[i]   = 1'b1;
        d_addr[i] = a;
        d_len[i]  = l;
        for (int b = 0; b <= int'(l); b++)
            exp_q[i].push_back({(b == int'(l)), beat_data(a, b)});
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom) & ~AW'(3);
    endfunction

    // One clock: observe handshakes at the falling edge, drive after rising edge.
    task automatic step();
        bit r_hs;
        @(negedge clk);
        r_hs = axi_rvalid && axi_rready;
        for (int i = 0; i < N; i++)
            if (req_valid[i] && req_ready[i]) pend[i] = 1'b0;
        if (axi_arvalid && !axi_arready) begin
            ar_stalls++;
            if (ar_hold > 0) ar_hold--;
        end
        if (axi_rvalid && !axi_rready) r_stalls++;
        if (r_hs) begin
            if (s_beat == int'(s_len)) s_busy = 1'b0;
            else s_beat++;
        end
        if (axi_arvalid && axi_arready) begin
            s_busy = 1'b1; s_addr = axi_araddr; s_len = axi_arlen; s_beat = 0; s_id = axi_arid;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
                if (auto_reissue[i] > 0) begin
                    auto_reissue[i]--;
                    issue(i, rand_addr(), 8'($urandom_range(0, 3)));
                end else if (rand_mode && $urandom_range(0, 3) == 0) begin
                    issue(i, rand_addr(), 8'($urandom_range(0, 7)));
                end
            end
            req_valid[i]           = pend[i];
            req_addr[i*AW +: AW]   = d_addr[i];
            req_len[i*8 +: 8]      = d_len[i];
        end
        axi_arready = (ar_hold > 0) ? 1'b0 : (rand_mode ? 1'($urandom_range(0, 1)) : 1'b1);
        if (!(axi_rvalid && !r_hs)) begin
            if (s_busy && (!rand_mode || $urandom_range(0, 2) != 0)) begin
                axi_rvalid = 1'b1;
                axi_rdata  = beat_data(s_addr, s_beat);
                axi_rlast  = (s_beat == int'(s_len));
                axi_rresp  = 2'($urandom_range(0, 3));
                axi_rid    = bad_rid ? IW'(5) : s_id;
            end else begin
                axi_rvalid = 1'b0;
                axi_rdata  = DW'($urandom);
                axi_rlast  = 1'($urandom_range(0, 1));
            end
        end
        if (hold_req >= 0 && s_busy && int'(s_id) == hold_req && s_beat == 1) begin
            rdy_hold[hold_req] = 3;
            hold_req = -1;
        end
        for (int i = 0; i < N; i++) begin
            if (rdy_hold[i] > 0) begin
                rd_ready[i] = 1'b0;
                rdy_hold[i]--;
            end else begin
                rd_ready[i] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    endtask

    function automatic bit busy_any();
        bit b = s_busy;
        for (int i = 0; i < N; i++)
            if (pend[i] || auto_reissue[i] > 0 || exp_q[i].size() != 0) b = 1'b1;
        return b;
    endfunction

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_any() && n < 3000) begin step(); n++; end
        if (busy_any()) chk({name, "_timeout"}, 64'd1, 64'd0);
        repeat (2) step();
    endtask

    task automatic clear_driver();
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; auto_reissue[i] = 0; rdy_hold[i] = 0; exp_q[i].delete();
        end
        s_busy = 0; req_valid = '0; axi_rvalid = 1'b0; ar_hold = 0; hold_req = -1;
    endtask

    // ---------------- monitor / reference model ----------------
    int            m_ptr, m_grant;
    bit            m_busy, m_arp, m_data, m_err;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_len;

    initial begin
        bit           busy0;
        int           w, idx;
        logic [N-1:0] exp_v;
        logic [DW:0]  e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ptr = 0; m_grant = 0; m_busy = 0; m_arp = 0; m_data = 0; m_err = 0;
                continue;
            end
            busy0 = m_busy;
            chk("arvalid", 64'(axi_arvalid), 64'(m_arp));
            if (m_arp) begin
                chk("arid", 64'(axi_arid), 64'(m_grant));
                chk("araddr", 64'(axi_araddr), 64'(m_addr));
                chk("arlen", 64'(axi_arlen), 64'(m_len));
            end
            chk("arsize", 64'(axi_arsize), 64'd2);
            chk("arburst", 64'(axi_arburst), 64'd1);
            exp_v = (m_data && axi_rvalid) ? (N'(1) << m_grant) : '0;
            chk("rd_valid", 64'(rd_valid), 64'(exp_v));
            chk("axi_rready", 64'(axi_rready), m_data ? 64'(rd_ready[m_grant]) : 64'd0);
            if (m_data && axi_rvalid)
                chk("rd_resp", 64'(rd_resp), 64'(axi_rresp));
            chk("err_rid", 64'(err_rid), 64'(m_err));
            for (int i = 0; i < N; i++) begin
                if (rd_valid[i] && rd_ready[i]) begin
                    if (exp_q[i].size() == 0) chk("rbeat_unexpected", 64'd1, 64'd0);
                    else begin
                        e = exp_q[i].pop_front();
                        chk("rbeat", 64'({rd_last, rd_data}), 64'(e));
                    end
                end
            end
            if (m_data && axi_rvalid && axi_rready) begin
`ifdef AXI_RD_ARB_RID_CHECK_EN
                if (axi_rid != IW'(m_grant)) m_err = 1;
`endif
                if (axi_rlast) begin m_data = 0; m_busy = 0; end
            end
            if (m_arp && axi_arvalid && axi_arready) begin
                m_arp = 0; m_data = 1; m_ptr = (m_grant + 1) % N;
            end
            if (!busy0) begin
                w = -1;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
                chk("req_ready", 64'(req_ready), (w < 0) ? 64'd0 : (64'd1 << w));
                if (w >= 0) begin
                    m_busy = 1; m_arp = 1; m_grant = w;
                    m_addr = req_addr[w*AW +: AW];
                    m_len  = req_len[w*8 +: 8];
                    grant_log.push_back(w);
                end
            end else begin
                chk("req_ready_busy", 64'(req_ready), 64'd0);
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic do_reset();
        clear_driver();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

`ifdef AXI_RD_ARB_RID_CHECK_EN
    localparam logic c_err_exp = 1'b1;
`else
    localparam logic c_err_exp = 1'b0;
`endif

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; d_addr[i] = '0; d_len[i] = '0; auto_reissue[i] = 0; rdy_hold[i] = 0;
        end
        do_reset();
        @(negedge clk);
        chk("rst_arvalid", 64'(axi_arvalid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rready", 64'(axi_rready), 64'd0);
        chk("rst_err", 64'(err_rid), 64'd0);
        chk("rst_ar_fields", {axi_araddr, axi_arlen, axi_arid}, 64'd0);

        // Simultaneous requests after reset, both kept valid for two bursts each
        grant_log.delete();
        auto_reissue[0] = 1; auto_reissue[1] = 1;
        issue(0, rand_addr(), 8'd2);
        issue(1, rand_addr(), 8'd1);
        wait_idle("rr");
        chk("rr_count", 64'(grant_log.size()), 64'd4);
        if (grant_log.size() == 4) begin
            chk("rr_g0", 64'(grant_log[0]), 64'd0);
            chk("rr_g1", 64'(grant_log[1]), 64'd1);
            chk("rr_g2", 64'(grant_log[2]), 64'd0);
            chk("rr_g3", 64'(grant_log[3]), 64'd1);
        end

        // Single 4-beat burst from requester 0
        grant_log.delete();
        issue(0, 32'h0000_1000, 8'd3);
        wait_idle("basic");
        chk("basic_grant", (grant_log.size() == 1) ? 64'(grant_log[0]) : 64'hFF, 64'd0);

        // AR stalled for 5 cycles
        ar_stalls = 0; ar_hold = 5;
        issue(2, 32'h0000_0800, 8'd1);
        wait_idle("arstall");
        chk("ar_stall_cycles", 64'(ar_stalls), 64'd5);

        // Requester 1 stalls beat 2 for 3 cycles
        r_stalls = 0; hold_req = 1;
        issue(1, 32'h0000_4000, 8'd3);
        wait_idle("rstall");
        chk("r_stall_cycles", 64'(r_stalls), 64'd3);

        // Randomized traffic
        rand_mode = 1;
        repeat (600) step();
        rand_mode = 0;
        wait_idle("random");

        // RID mismatch injection
        bad_rid = 1;
        issue(0, 32'h0000_5000, 8'd1);
        wait_idle("rid");
        bad_rid = 0;
        chk("err_rid_set", 64'(err_rid), 64'(c_err_exp));
        issue(0, 32'h0000_6000, 8'd0);
        wait_idle("rid2");
        chk("err_rid_sticky", 64'(err_rid), 64'(c_err_exp));

        // Reset during beat 2 of a burst
        issue(0, 32'h0000_3000, 8'd3);
        n = 0;
        while (!(s_busy && s_beat == 1) && n < 200) begin step(); n++; end
        chk("rst_mid_reached", 64'(s_busy && s_beat == 1), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_arvalid", 64'(axi_arvalid), 64'd0);
        chk("mid_rst_rready", 64'(axi_rready), 64'd0);
        chk("mid_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_err", 64'(err_rid), 64'd0);
        chk("mid_rst_ar_fields", {axi_araddr, axi_arlen, axi_arid}, 64'd0);
        clear_driver();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        grant_log.delete();
        issue(1, 32'h0000_2000, 8'd0);
        wait_idle("post_rst");
        chk("post_rst_grant", (grant_log.size() == 1) ? 64'(grant_log[0]) : 64'hFF, 64'd1);

        for (int i = 0; i < N; i++)
            chk("exp_q_drained", 64'(exp_q[i].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
